// File: rtl/victim_cache_ctrl.sv
// Fully associative victim cache between L2 and physical memory: swap-on-hit reads,
// true-LRU replacement, write-back of dirty victims and idle-time cleaning of dirty lines.
module victim_cache_ctrl #(
    parameter int NUM_ENTRIES = 8,
    parameter int ADDR_WIDTH  = 16,
    parameter int OFFSET_BITS = 5,
    parameter int LINE_WIDTH  = 256,
    parameter bit CLEAN_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  l2_read,
    input  logic                  l2_write,
    input  logic [ADDR_WIDTH-1:0] l2_address,
    input  logic [LINE_WIDTH-1:0] l2_wdata,
    input  logic                  l2_wdirty,
    output logic                  l2_resp,
    output logic                  l2_hit,
    output logic [LINE_WIDTH-1:0] l2_rdata,
    output logic                  l2_rdirty,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic                  pmem_resp
);
    localparam int TAG_W = ADDR_WIDTH - OFFSET_BITS;
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic [1:0] {S_IDLE, S_EVICT, S_CLEAN} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   rst_q;
    logic [NUM_ENTRIES-1:0] valid_q, valid_d, dirty_q, dirty_d;
    logic [TAG_W-1:0]       tag_q  [NUM_ENTRIES];
    logic [TAG_W-1:0]       tag_d  [NUM_ENTRIES];
    logic [LINE_WIDTH-1:0]  data_q [NUM_ENTRIES];
    logic [LINE_WIDTH-1:0]  data_d [NUM_ENTRIES];
    logic [IDX_W-1:0]       age_q  [NUM_ENTRIES];
    logic [IDX_W-1:0]       age_d  [NUM_ENTRIES];

    logic [TAG_W-1:0] req_tag;
    logic             hit_any, free_any, dirty_any, blk, install, touch;
    logic [IDX_W-1:0] hit_idx, free_idx, lru_idx, dirty_idx, vict_idx, touch_idx;
    logic             unused_offset;

    assign req_tag       = l2_address[ADDR_WIDTH-1:OFFSET_BITS];
    assign unused_offset = ^l2_address[OFFSET_BITS-1:0];
    // Outputs and state updates are held off during reset and the cycle after it.
    assign blk           = rst | rst_q;

    always_comb begin : lookup
        hit_any   = 1'b0;
        hit_idx   = '0;
        free_any  = 1'b0;
        free_idx  = '0;
        dirty_any = 1'b0;
        dirty_idx = '0;
        lru_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == req_tag)) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
            if (valid_q[i] && dirty_q[i]) begin
                dirty_any = 1'b1;
                dirty_idx = IDX_W'(i);
            end
            if (age_q[i] == AGE_MAX) lru_idx = IDX_W'(i);
        end
        vict_idx = free_any ? free_idx : lru_idx;
    end

    always_comb begin : control
        state_d      = state_q;
        idx_d        = idx_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        data_d       = data_q;
        install      = 1'b0;
        touch        = 1'b0;
        touch_idx    = '0;
        l2_resp      = 1'b0;
        l2_hit       = 1'b0;
        l2_rdata     = '0;
        l2_rdirty    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        if (!blk) begin
            unique case (state_q)
                S_IDLE: begin
                    if (l2_write) begin
                        if (hit_any) begin
                            l2_resp          = 1'b1;
                            data_d[hit_idx]  = l2_wdata;
                            dirty_d[hit_idx] = dirty_q[hit_idx] | l2_wdirty;
                            touch            = 1'b1;
                            touch_idx        = hit_idx;
                        end else if (!valid_q[vict_idx] || !dirty_q[vict_idx]) begin
                            l2_resp   = 1'b1;
                            install   = 1'b1;
                            touch_idx = vict_idx;
                        end else begin
                            idx_d   = vict_idx;
                            state_d = S_EVICT;
                        end
                    end else if (l2_read) begin
                        l2_resp = 1'b1;
                        l2_hit  = hit_any;
                        if (hit_any) begin
                            l2_rdata         = data_q[hit_idx];
                            l2_rdirty        = dirty_q[hit_idx];
                            valid_d[hit_idx] = 1'b0;
                        end
                    end else if (CLEAN_EN && dirty_any) begin
                        idx_d   = dirty_idx;
                        state_d = S_CLEAN;
                    end
                end
                S_EVICT: begin
                    pmem_write   = 1'b1;
                    pmem_address = {tag_q[idx_q], {OFFSET_BITS{1'b0}}};
                    pmem_wdata   = data_q[idx_q];
                    if (pmem_resp) begin
                        l2_resp   = 1'b1;
                        install   = 1'b1;
                        touch_idx = idx_q;
                        state_d   = S_IDLE;
                    end
                end
                S_CLEAN: begin
                    pmem_write   = 1'b1;
                    pmem_address = {tag_q[idx_q], {OFFSET_BITS{1'b0}}};
                    pmem_wdata   = data_q[idx_q];
                    if (pmem_resp) begin
                        dirty_d[idx_q] = 1'b0;
                        state_d        = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (install) begin
            valid_d[touch_idx] = 1'b1;
            dirty_d[touch_idx] = l2_wdirty;
            tag_d[touch_idx]   = req_tag;
            data_d[touch_idx]  = l2_wdata;
            touch              = 1'b1;
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            age_d[i] = (touch && (age_q[i] < age_q[touch_idx])) ? age_q[i] + 1'b1 : age_q[i];
        end
        if (touch) age_d[touch_idx] = '0;
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
                age_q[i]  <= IDX_W'(i);
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            age_q   <= age_d;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(l2_read && l2_write))
        else $error("victim_cache_ctrl: l2_read and l2_write asserted together");

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Directed bench for victim_cache_ctrl: fill, swap reads, dirty eviction, write-hit merge,
// idle cleaning with a stalled read, and reset during eviction.
module tb_victim_cache_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         l2_read, l2_write, l2_wdirty;
    logic [15:0]  l2_address;
    logic [255:0] l2_wdata;
    logic         l2_resp, l2_hit, l2_rdirty;
    logic [255:0] l2_rdata;
    logic         pmem_write, pmem_resp;
    logic [15:0]  pmem_address;
    logic [255:0] pmem_wdata;

    int n_cmp = 0;
    int n_err = 0;

    victim_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
        .l2_wdata(l2_wdata), .l2_wdirty(l2_wdirty),
        .l2_resp(l2_resp), .l2_hit(l2_hit), .l2_rdata(l2_rdata), .l2_rdirty(l2_rdirty),
        .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] line_of(input logic [15:0] a);
        return {8{a ^ 16'h5A5A, a}};
    endfunction

    function automatic logic [255:0] dline_of(input logic [15:0] a);
        return {8{16'hD1D1, a}};
    endfunction

    task automatic set_req(input bit rd, input bit wr, input logic [15:0] a,
                           input logic [255:0] d, input bit dty);
        l2_read    = rd;
        l2_write   = wr;
        l2_address = a;
        l2_wdata   = d;
        l2_wdirty  = dty;
    endtask

    task automatic set_idle();
        set_req(1'b0, 1'b0, 16'h0, '0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        pmem_resp = 1'b0;
        set_req(1'b1, 1'b0, 16'h0020, '0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b0 || pmem_write !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs resp=%b pmem_write=%b required 0/0", l2_resp, pmem_write);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b0) begin
            n_err++;
            $display("FAIL reset_after_cycle resp=%b required 0", l2_resp);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1 || l2_hit !== 1'b0 || l2_rdata !== '0) begin
            n_err++;
            $display("FAIL reset_empty_read resp=%b hit=%b rdata_nz=%b required 1/0/0",
                     l2_resp, l2_hit, |l2_rdata);
        end
        next_cycle();
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 8; k++) begin
            set_req(1'b0, 1'b1, 16'(k * 32), line_of(16'(k * 32)), 1'b0);
            @(negedge clk);
            n_cmp++;
            if (l2_resp !== 1'b1 || pmem_write !== 1'b0) begin
                n_err++;
                $display("FAIL fill[%0d] resp=%b pmem_write=%b required 1/0", k, l2_resp, pmem_write);
            end
            next_cycle();
        end
    endtask

    task automatic test_read_swap();
        set_req(1'b0, 1'b1, 16'h0040, dline_of(16'h0040), 1'b1);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1) begin
            n_err++;
            $display("FAIL swap_write_hit resp=%b required 1", l2_resp);
        end
        next_cycle();
        set_req(1'b1, 1'b0, 16'h0040, '0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1 || l2_hit !== 1'b1 || l2_rdata !== dline_of(16'h0040) || l2_rdirty !== 1'b1) begin
            n_err++;
            $display("FAIL swap_read_hit resp=%b hit=%b rdata=%h rdirty=%b required 1/1/%h/1",
                     l2_resp, l2_hit, l2_rdata[31:0], l2_rdirty, dline_of(16'h0040) & 256'hFFFF_FFFF);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1 || l2_hit !== 1'b0 || l2_rdata !== '0) begin
            n_err++;
            $display("FAIL swap_read_again resp=%b hit=%b required 1/0 with zero rdata", l2_resp, l2_hit);
        end
        next_cycle();
    endtask

    task automatic test_evict();
        logic [15:0] touch_list [8];
        touch_list = '{16'h0300, 16'h0060, 16'h0080, 16'h00A0, 16'h00C0, 16'h00E0, 16'h0100, 16'h0000};
        set_req(1'b0, 1'b1, 16'h0300, line_of(16'h0300), 1'b0);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1) begin
            n_err++;
            $display("FAIL evict_refill resp=%b required 1", l2_resp);
        end
        next_cycle();
        set_req(1'b0, 1'b1, 16'h0020, dline_of(16'h0020), 1'b1);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1) begin
            n_err++;
            $display("FAIL evict_dirty_0020 resp=%b required 1", l2_resp);
        end
        next_cycle();
        for (int k = 0; k < 7; k++) begin
            set_req(1'b0, 1'b1, touch_list[k], line_of(touch_list[k]), 1'b0);
            @(negedge clk);
            n_cmp++;
            if (l2_resp !== 1'b1) begin
                n_err++;
                $display("FAIL evict_touch[%0d] resp=%b required 1", k, l2_resp);
            end
            next_cycle();
        end
        set_req(1'b0, 1'b1, 16'h0200, line_of(16'h0200), 1'b0);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b0 || pmem_write !== 1'b0) begin
            n_err++;
            $display("FAIL evict_miss_stall resp=%b pmem_write=%b required 0/0", l2_resp, pmem_write);
        end
        next_cycle();
        for (int c = 1; c <= 5; c++) begin
            pmem_resp = (c == 5);
            @(negedge clk);
            n_cmp++;
            if (pmem_write !== 1'b1 || pmem_address !== 16'h0020 || pmem_wdata !== dline_of(16'h0020)
                || l2_resp !== (c == 5)) begin
                n_err++;
                $display("FAIL evict_wb[%0d] pmem_write=%b addr=%h resp=%b required 1/0020/%0d",
                         c, pmem_write, pmem_address, l2_resp, (c == 5));
            end
            next_cycle();
        end
        pmem_resp = 1'b0;
        set_req(1'b1, 1'b0, 16'h0020, '0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1 || l2_hit !== 1'b0) begin
            n_err++;
            $display("FAIL evict_old_gone resp=%b hit=%b required 1/0", l2_resp, l2_hit);
        end
        next_cycle();
        set_req(1'b1, 1'b0, 16'h0200, '0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1 || l2_hit !== 1'b1 || l2_rdata !== line_of(16'h0200) || l2_rdirty !== 1'b0) begin
            n_err++;
            $display("FAIL evict_new_hit resp=%b hit=%b rdirty=%b required 1/1/0 with installed data",
                     l2_resp, l2_hit, l2_rdirty);
        end
        next_cycle();
    endtask

    task automatic test_write_hit_dirty();
        set_req(1'b0, 1'b1, 16'h0300, dline_of(16'h0300), 1'b1);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1) begin
            n_err++;
            $display("FAIL whit_dirty resp=%b required 1", l2_resp);
        end
        next_cycle();
        set_req(1'b0, 1'b1, 16'h0300, ~line_of(16'h0300), 1'b0);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1) begin
            n_err++;
            $display("FAIL whit_clean resp=%b required 1", l2_resp);
        end
        next_cycle();
        set_req(1'b0, 1'b1, 16'h0400, line_of(16'h0400), 1'b0);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1) begin
            n_err++;
            $display("FAIL whit_fill_free resp=%b required 1", l2_resp);
        end
        next_cycle();
        set_req(1'b0, 1'b1, 16'h0500, line_of(16'h0500), 1'b0);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1 || pmem_write !== 1'b0) begin
            n_err++;
            $display("FAIL whit_full_miss resp=%b pmem_write=%b required 1/0", l2_resp, pmem_write);
        end
        next_cycle();
        set_req(1'b1, 1'b0, 16'h0060, '0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1 || l2_hit !== 1'b0) begin
            n_err++;
            $display("FAIL whit_lru_replaced resp=%b hit=%b required 1/0", l2_resp, l2_hit);
        end
        next_cycle();
        set_req(1'b1, 1'b0, 16'h0300, '0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1 || l2_hit !== 1'b1 || l2_rdata !== ~line_of(16'h0300) || l2_rdirty !== 1'b1) begin
            n_err++;
            $display("FAIL whit_mru_kept resp=%b hit=%b rdirty=%b required 1/1/1 with merged data",
                     l2_resp, l2_hit, l2_rdirty);
        end
        next_cycle();
    endtask

    task automatic test_clean();
        set_req(1'b0, 1'b1, 16'h0500, dline_of(16'h0500), 1'b1);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1) begin
            n_err++;
            $display("FAIL clean_dirty_e2 resp=%b required 1", l2_resp);
        end
        next_cycle();
        set_req(1'b0, 1'b1, 16'h00C0, dline_of(16'h00C0), 1'b1);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1) begin
            n_err++;
            $display("FAIL clean_dirty_e5 resp=%b required 1", l2_resp);
        end
        next_cycle();
        set_idle();
        @(negedge clk);
        n_cmp++;
        if (pmem_write !== 1'b0) begin
            n_err++;
            $display("FAIL clean_idle_latch pmem_write=%b required 0", pmem_write);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (pmem_write !== 1'b1 || pmem_address !== 16'h0500 || pmem_wdata !== dline_of(16'h0500)) begin
            n_err++;
            $display("FAIL clean_first pmem_write=%b addr=%h required 1/0500", pmem_write, pmem_address);
        end
        next_cycle();
        set_req(1'b1, 1'b0, 16'h0100, '0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b0 || pmem_write !== 1'b1) begin
            n_err++;
            $display("FAIL clean_stall_a resp=%b pmem_write=%b required 0/1", l2_resp, pmem_write);
        end
        next_cycle();
        pmem_resp = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b0 || pmem_write !== 1'b1) begin
            n_err++;
            $display("FAIL clean_stall_b resp=%b pmem_write=%b required 0/1", l2_resp, pmem_write);
        end
        next_cycle();
        pmem_resp = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1 || l2_hit !== 1'b1 || l2_rdata !== line_of(16'h0100) || pmem_write !== 1'b0) begin
            n_err++;
            $display("FAIL clean_stalled_read resp=%b hit=%b pmem_write=%b required 1/1/0",
                     l2_resp, l2_hit, pmem_write);
        end
        next_cycle();
        set_idle();
        @(negedge clk);
        n_cmp++;
        if (pmem_write !== 1'b0) begin
            n_err++;
            $display("FAIL clean_second_latch pmem_write=%b required 0", pmem_write);
        end
        next_cycle();
        pmem_resp = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (pmem_write !== 1'b1 || pmem_address !== 16'h00C0 || pmem_wdata !== dline_of(16'h00C0)) begin
            n_err++;
            $display("FAIL clean_second pmem_write=%b addr=%h required 1/00c0", pmem_write, pmem_address);
        end
        next_cycle();
        pmem_resp = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (pmem_write !== 1'b0) begin
                n_err++;
                $display("FAIL clean_done[%0d] pmem_write=%b required 0", c, pmem_write);
            end
            next_cycle();
        end
        set_req(1'b1, 1'b0, 16'h0500, '0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1 || l2_hit !== 1'b1 || l2_rdirty !== 1'b0 || l2_rdata !== dline_of(16'h0500)) begin
            n_err++;
            $display("FAIL clean_cleared_e2 resp=%b hit=%b rdirty=%b required 1/1/0", l2_resp, l2_hit, l2_rdirty);
        end
        next_cycle();
        set_req(1'b1, 1'b0, 16'h00C0, '0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b1 || l2_hit !== 1'b1 || l2_rdirty !== 1'b0) begin
            n_err++;
            $display("FAIL clean_cleared_e5 resp=%b hit=%b rdirty=%b required 1/1/0", l2_resp, l2_hit, l2_rdirty);
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_reset_evict();
        logic [15:0] probe [3];
        probe = '{16'h0020, 16'h0100, 16'h0600};
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        next_cycle();
        for (int k = 1; k <= 8; k++) begin
            set_req(1'b0, 1'b1, 16'(k * 32), line_of(16'(k * 32)), (k == 1));
            @(negedge clk);
            n_cmp++;
            if (l2_resp !== 1'b1) begin
                n_err++;
                $display("FAIL rstev_fill[%0d] resp=%b required 1", k, l2_resp);
            end
            next_cycle();
        end
        set_req(1'b0, 1'b1, 16'h0600, line_of(16'h0600), 1'b0);
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (pmem_write !== 1'b1 || pmem_address !== 16'h0020 || l2_resp !== 1'b0) begin
            n_err++;
            $display("FAIL rstev_evicting pmem_write=%b addr=%h resp=%b required 1/0020/0",
                     pmem_write, pmem_address, l2_resp);
        end
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b0 || pmem_write !== 1'b0) begin
            n_err++;
            $display("FAIL rstev_in_reset resp=%b pmem_write=%b required 0/0", l2_resp, pmem_write);
        end
        next_cycle();
        rst = 1'b0;
        set_idle();
        @(negedge clk);
        n_cmp++;
        if (l2_resp !== 1'b0 || pmem_write !== 1'b0) begin
            n_err++;
            $display("FAIL rstev_after resp=%b pmem_write=%b required 0/0", l2_resp, pmem_write);
        end
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            set_req(1'b1, 1'b0, probe[k], '0, 1'b0);
            @(negedge clk);
            n_cmp++;
            if (l2_resp !== 1'b1 || l2_hit !== 1'b0 || pmem_write !== 1'b0) begin
                n_err++;
                $display("FAIL rstev_empty[%0d] resp=%b hit=%b pmem_write=%b required 1/0/0",
                         k, l2_resp, l2_hit, pmem_write);
            end
            next_cycle();
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_read_swap();
        test_evict();
        test_write_hit_dirty();
        test_clean();
        test_reset_evict();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached after %0d comparisons", n_cmp);
        $fatal(1, "time limit");
    end
endmodule
